// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler.
package pipeline_hazard_ctrl_pkg;

    localparam int DEF_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_FLUSH = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_JMP  = 2'd1,
        BR_BEQ  = 2'd2,
        BR_BNE  = 2'd3
    } is_br_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID-stage sources and an EX-stage load.
module hazard_detect #(
    parameter int REG_ADDR_W = pipeline_hazard_ctrl_pkg::DEF_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  use_src2,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  mem_read,
    output logic                  hit
);

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    always_comb begin
        hit = mem_read && (dest != '0) &&
              ((dest == src1) || (use_src2 && (dest == src2)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler: load-use interlock, taken-branch flush, data-memory wait.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int BR_PENALTY  = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use_src2,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_mem_read,
    input  logic                  ex_br_taken,
    input  logic                  mem_access,
    input  logic                  mem_ready,
    output logic                  freeze_pc,
    output logic                  freeze_if_id,
    output logic                  flush_if_id,
    output logic                  bubble_id_ex,
    output logic                  freeze_ex_mem,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [1:0] BR_CNT_INIT = 2'(BR_PENALTY - 1);
    // wait_cnt holds the stall cycles already completed, so the current cycle is
    // number wait_cnt+1; the wait aborts on the MEM_TIMEOUT-th frozen cycle.
    localparam logic [7:0] WAIT_LAST   = 8'(MEM_TIMEOUT - 1);

    hz_state_t  state;
    logic [1:0] br_cnt;
    logic [7:0] wait_cnt;
    logic       hit;
    logic       mem_wait;

    hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard_detect (
        .src1     (id_src1),
        .src2     (id_src2),
        .use_src2 (id_use_src2),
        .dest     (ex_dest),
        .mem_read (ex_mem_read),
        .hit      (hit)
    );

    // A pending access stalls from RUN, and also preempts an ongoing branch flush.
    always_comb begin
        mem_wait = (state == MEM_WAIT) || (mem_access && !mem_ready);
    end

    // Per-cycle strobes; priority is memory wait, then branch flush, then load-use.
    always_comb begin
        freeze_pc     = 1'b0;
        freeze_if_id  = 1'b0;
        flush_if_id   = 1'b0;
        bubble_id_ex  = 1'b0;
        freeze_ex_mem = 1'b0;
        if (rst) begin
            if (mem_wait) begin
                freeze_pc     = 1'b1;
                freeze_if_id  = 1'b1;
                freeze_ex_mem = 1'b1;
            end else if (state == BR_FLUSH || ex_br_taken) begin
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else if (hit) begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    // Scheduler state, flush/wait counters, sticky error and stall statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            br_cnt    <= '0;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (freeze_pc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            unique case (state)
                RUN: begin
                    if (mem_wait) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end else if (ex_br_taken && (BR_PENALTY > 1)) begin
                        state  <= BR_FLUSH;
                        br_cnt <= BR_CNT_INIT;
                    end
                end
                BR_FLUSH: begin
                    if (mem_wait) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end else if (br_cnt == 2'd1) begin
                        state <= RUN;
                    end else begin
                        br_cnt <= br_cnt - 2'd1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_err <= 1'b1;
                        state   <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (BR_PENALTY=2, MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

    // Strobe vector order: {freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_ex_mem}
    localparam logic [4:0] S_NONE  = 5'b00000;
    localparam logic [4:0] S_LOAD  = 5'b11010;
    localparam logic [4:0] S_FLUSH = 5'b00110;
    localparam logic [4:0] S_MEM   = 5'b11001;

    logic        clk;
    logic        rst;
    logic [4:0]  id_src1, id_src2, ex_dest;
    logic        id_use_src2, ex_mem_read, ex_br_taken, mem_access, mem_ready;
    logic        freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_ex_mem;
    logic        mem_err;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    typedef struct {
        string      name;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       use2;
        logic [4:0] d;
        logic       mr;
        logic       br;
        logic       acc;
        logic       rdy;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[8];

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (5),
        .BR_PENALTY (2),
        .MEM_TIMEOUT(4),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_use_src2  (id_use_src2),
        .ex_dest      (ex_dest),
        .ex_mem_read  (ex_mem_read),
        .ex_br_taken  (ex_br_taken),
        .mem_access   (mem_access),
        .mem_ready    (mem_ready),
        .freeze_pc    (freeze_pc),
        .freeze_if_id (freeze_if_id),
        .flush_if_id  (flush_if_id),
        .bubble_id_ex (bubble_id_ex),
        .freeze_ex_mem(freeze_ex_mem),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] s1, input logic [4:0] s2, input logic use2,
                          input logic [4:0] d, input logic mr, input logic br,
                          input logic acc, input logic rdy);
        id_src1     = s1;
        id_src2     = s2;
        id_use_src2 = use2;
        ex_dest     = d;
        ex_mem_read = mr;
        ex_br_taken = br;
        mem_access  = acc;
        mem_ready   = rdy;
    endtask

    // Check strobes mid-cycle, account the stall, then advance past the next edge.
    task automatic cyc(input string name, input logic [4:0] exp);
        #2;
        chk(name, {27'd0, freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_ex_mem},
            {27'd0, exp});
        if (exp[4]) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{"idle",        5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, S_NONE};
        tbl[1] = '{"lu_src1",     5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, S_LOAD};
        tbl[2] = '{"r0_no_haz",   5'd0, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, S_NONE};
        tbl[3] = '{"src2_unused", 5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, S_NONE};
        tbl[4] = '{"lu_src2",     5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, S_LOAD};
        tbl[5] = '{"no_load",     5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, S_NONE};
        tbl[6] = '{"mem_1cyc",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, S_NONE};
        tbl[7] = '{"diff_regs",   5'd4, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, S_NONE};

        // Reset: strobes gated even with a live load-use pattern.
        rst = 1'b0;
        set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        chk("rst_strobes", {27'd0, freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_ex_mem}, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single-cycle patterns that stay in RUN.
        for (int i = 0; i < 8; i++) begin
            set_in(tbl[i].s1, tbl[i].s2, tbl[i].use2, tbl[i].d, tbl[i].mr,
                   tbl[i].br, tbl[i].acc, tbl[i].rdy);
            cyc(tbl[i].name, tbl[i].exp);
        end
        chk("stall_after_tbl", {16'd0, stall_cnt}, exp_stall);

        // Taken branch with a load-use hit present: two flush cycles, no freeze.
        set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("br_c1", S_FLUSH);
        ex_br_taken = 1'b0;
        cyc("br_c2", S_FLUSH);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("br_done", S_NONE);

        // Memory wait: ready low for three cycles, then high.
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("mw_wait", S_MEM);
        mem_ready = 1'b1;
        cyc("mw_ready", S_MEM);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("mw_after", S_NONE);
        chk("mw_no_err", {31'd0, mem_err}, 32'd0);
        chk("mw_stall_cnt", {16'd0, stall_cnt}, exp_stall);

        // Timeout after four frozen cycles; error stays set through a clean access.
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc("to_wait", S_MEM);
        chk("to_err_set", {31'd0, mem_err}, 32'd1);
        mem_access = 1'b0;
        cyc("to_after", S_NONE);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("to_clean", S_NONE);
        chk("to_err_sticky", {31'd0, mem_err}, 32'd1);

        // Branch held during a memory wait: no flush until the wait ends.
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("sim_w1", S_MEM);
        cyc("sim_w2", S_MEM);
        mem_ready = 1'b1;
        cyc("sim_rdy", S_MEM);
        mem_access = 1'b0;
        cyc("sim_br1", S_FLUSH);
        ex_br_taken = 1'b0;
        cyc("sim_br2", S_FLUSH);
        cyc("sim_done", S_NONE);
        chk("sim_stall_cnt", {16'd0, stall_cnt}, exp_stall);

        // Reset asserted in the middle of a memory wait.
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("rw_enter", S_MEM);
        #1;
        rst = 1'b0;
        #1;
        chk("rw_strobes", {27'd0, freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_ex_mem}, 32'd0);
        chk("rw_err_clr", {31'd0, mem_err}, 32'd0);
        chk("rw_cnt_clr", {16'd0, stall_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_stall = 0;
        mem_ready = 1'b1;
        cyc("rw_run", S_NONE);
        chk("rw_stall_cnt", {16'd0, stall_cnt}, exp_stall);
        chk("rw_err_final", {31'd0, mem_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
